// File: rtl/stopwatch.sv
// Count-up BCD MM:SS stopwatch with start/stop, clear and lap capture from raw button levels.
// Latency: button edge acts on the first clk edge it is sampled; outputs are registered (1 edge).
// Backpressure: none; free-running, the display mux samples outputs whenever it likes.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   enable_mode         stopwatch mode selected; low stops the watch and masks buttons
//   btn_start/lap/clear raw button levels, rising edges detected internally
//   sw_*                live elapsed time, BCD digits
//   lap_*               last captured lap, BCD digits
//   lap_valid/count     lap captured since clear / number of laps (saturating at 15)
//   running, overflow   counting / sticky 99:59 saturation
//
// Optional feature: define STOPWATCH_WRAP_EN to wrap 99:59 -> 00:00 and keep running
// instead of saturating with a sticky overflow.
module stopwatch #(
  parameter int unsigned CLK_FREQ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_mode,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] sw_m10,
  output logic [3:0] sw_m1,
  output logic [3:0] sw_s10,
  output logic [3:0] sw_s1,
  output logic [3:0] lap_m10,
  output logic [3:0] lap_m1,
  output logic [3:0] lap_s10,
  output logic [3:0] lap_s1,
  output logic       lap_valid,
  output logic [3:0] lap_count,
  output logic       running,
  output logic       overflow
);

  logic        prev_start_q, prev_lap_q, prev_clear_q;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] sw_q, sw_d;    // {m10, m1, s10, s1}
  logic [15:0] lap_q, lap_d;
  logic        lap_valid_q, lap_valid_d;
  logic [3:0]  lap_count_q, lap_count_d;
  logic        running_q, running_d;
  logic        overflow_q, overflow_d;

  logic start_p, lap_p, clear_p, tick;

  // Buttons are masked by mode here; the history registers still sample every
  // cycle so a button held across a mode switch never produces a late pulse.
  assign start_p = enable_mode & btn_start & ~prev_start_q;
  assign lap_p   = enable_mode & btn_lap   & ~prev_lap_q;
  assign clear_p = enable_mode & btn_clear & ~prev_clear_q;
  assign tick    = running_q && (cnt_q == 32'(CLK_FREQ - 1));

  always_comb begin
    cnt_d       = cnt_q;
    sw_d        = sw_q;
    lap_d       = lap_q;
    lap_valid_d = lap_valid_q;
    lap_count_d = lap_count_q;
    running_d   = running_q;
    overflow_d  = overflow_q;

    if (!enable_mode) begin
      running_d = 1'b0;
    end else if (clear_p) begin
      cnt_d       = '0;
      sw_d        = '0;
      lap_d       = '0;
      lap_valid_d = 1'b0;
      lap_count_d = '0;
      running_d   = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      // Prescaler keeps its fraction across stop/resume.
      if (running_q) cnt_d = tick ? '0 : cnt_q + 32'd1;

      // Lap captures the pre-increment value even on a tick edge.
      if (lap_p && running_q) begin
        lap_d       = sw_q;
        lap_valid_d = 1'b1;
        if (lap_count_q != 4'd15) lap_count_d = lap_count_q + 4'd1;
      end

      if (start_p && !overflow_q) running_d = ~running_q;

      // Tick follows the pre-edge running state, so a stop on the tick edge
      // still counts that second.
      if (tick) begin
        if (sw_q == 16'h9959) begin
`ifdef STOPWATCH_WRAP_EN
          sw_d = '0;
`else
          running_d  = 1'b0;
          overflow_d = 1'b1;
`endif
        end else if (sw_q[3:0] != 4'd9) begin
          sw_d[3:0] = sw_q[3:0] + 4'd1;
        end else begin
          sw_d[3:0] = 4'd0;
          if (sw_q[7:4] != 4'd5) begin
            sw_d[7:4] = sw_q[7:4] + 4'd1;
          end else begin
            sw_d[7:4] = 4'd0;
            if (sw_q[11:8] != 4'd9) begin
              sw_d[11:8] = sw_q[11:8] + 4'd1;
            end else begin
              sw_d[11:8]  = 4'd0;
              sw_d[15:12] = sw_q[15:12] + 4'd1;  // never 9 here: 99:59 handled above
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_start_q <= 1'b0;
      prev_lap_q   <= 1'b0;
      prev_clear_q <= 1'b0;
      cnt_q        <= '0;
      sw_q         <= '0;
      lap_q        <= '0;
      lap_valid_q  <= 1'b0;
      lap_count_q  <= '0;
      running_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      prev_start_q <= btn_start;
      prev_lap_q   <= btn_lap;
      prev_clear_q <= btn_clear;
      cnt_q        <= cnt_d;
      sw_q         <= sw_d;
      lap_q        <= lap_d;
      lap_valid_q  <= lap_valid_d;
      lap_count_q  <= lap_count_d;
      running_q    <= running_d;
      overflow_q   <= overflow_d;
    end
  end

  assign {sw_m10, sw_m1, sw_s10, sw_s1}     = sw_q;
  assign {lap_m10, lap_m1, lap_s10, lap_s1} = lap_q;
  assign lap_valid = lap_valid_q;
  assign lap_count = lap_count_q;
  assign running   = running_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch (CLK_FREQ=10): expected states are queued tagged with
// the cycle they belong to; a monitor samples on the falling edge and compares.
// Inputs change 2 time units after the rising edge.
module tb_stopwatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_mode;
  logic       btn_start, btn_lap, btn_clear;
  logic [3:0] sw_m10, sw_m1, sw_s10, sw_s1;
  logic [3:0] lap_m10, lap_m1, lap_s10, lap_s1;
  logic       lap_valid;
  logic [3:0] lap_count;
  logic       running, overflow;

  stopwatch #(.CLK_FREQ(10)) dut (
    .clk(clk), .rst(rst), .enable_mode(enable_mode),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .sw_m10(sw_m10), .sw_m1(sw_m1), .sw_s10(sw_s10), .sw_s1(sw_s1),
    .lap_m10(lap_m10), .lap_m1(lap_m1), .lap_s10(lap_s10), .lap_s1(lap_s1),
    .lap_valid(lap_valid), .lap_count(lap_count),
    .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [38:0] st;   // {sw, lap, lap_valid, lap_count, running, overflow}
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every queued expectation tagged with the current cycle.
  always @(negedge clk) begin
    logic [38:0] act;
    act = {sw_m10, sw_m1, sw_s10, sw_s1, lap_m10, lap_m1, lap_s10, lap_s1,
           lap_valid, lap_count, running, overflow};
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (e.cyc != cyc || act !== e.st) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h want %h (tagged cyc %0d)", n, cyc, act, e.st, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [15:0] sw, input logic [15:0] lap,
                     input logic lv, input logic [3:0] lc, input logic run, input logic ov);
    exp_t e;
    e.cyc = cyc;
    e.st  = {sw, lap, lv, lc, run, ov};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic press_start();
    btn_start = 1'b1; step(1); btn_start = 1'b0;
  endtask
  task automatic press_lap();
    btn_lap = 1'b1; step(1); btn_lap = 1'b0;
  endtask
  task automatic press_clear();
    btn_clear = 1'b1; step(1); btn_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable_mode = 1'b0;
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    step(2);
    chk("reset", 16'h0000, 16'h0000, 0, 0, 0, 0);
    rst = 1'b0; enable_mode = 1'b1;
    step(1);

    // Start timing and fractional-second retention
    press_start();
    chk("start_edge", 16'h0000, 16'h0000, 0, 0, 1, 0);
    step(9);  chk("pre_first_tick", 16'h0000, 16'h0000, 0, 0, 1, 0);
    step(1);  chk("first_tick",     16'h0001, 16'h0000, 0, 0, 1, 0);
    step(15); chk("run_25",         16'h0002, 16'h0000, 0, 0, 1, 0);
    press_start(); step(30);
    chk("stopped_hold", 16'h0002, 16'h0000, 0, 0, 0, 0);
    press_start(); step(3);
    chk("resume_pre",  16'h0002, 16'h0000, 0, 0, 1, 0);
    step(1);
    chk("resume_frac", 16'h0003, 16'h0000, 0, 0, 1, 0);

    // Laps
    step(41); press_lap();
    chk("lap_first",   16'h0007, 16'h0007, 1, 1, 1, 0);
    step(27); press_lap();
    chk("lap_on_tick", 16'h0010, 16'h0009, 1, 2, 1, 0);
    for (int i = 0; i < 13; i++) begin
      step(1); press_lap();
    end
    chk("lap_count_15", 16'h0012, 16'h0012, 1, 15, 1, 0);
    step(1); press_lap();
    chk("lap_count_sat", 16'h0012, 16'h0012, 1, 15, 1, 0);
    press_start();
    chk("stop_2", 16'h0012, 16'h0012, 1, 15, 0, 0);
    step(1); press_lap();
    chk("lap_while_stopped", 16'h0012, 16'h0012, 1, 15, 0, 0);

    // Clear beats start in the same cycle
    step(1);
    btn_clear = 1'b1; btn_start = 1'b1;
    step(1);
    btn_clear = 1'b0; btn_start = 1'b0;
    chk("clear_start_same", 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Mode switch
    step(1); press_start(); step(42);
    chk("run_before_mode", 16'h0004, 16'h0000, 0, 0, 1, 0);
    enable_mode = 1'b0; step(1);
    chk("mode_off", 16'h0004, 16'h0000, 0, 0, 0, 0);
    btn_start = 1'b1; step(1);
    chk("start_ignored_mode_off", 16'h0004, 16'h0000, 0, 0, 0, 0);
    enable_mode = 1'b1; step(1);
    chk("held_across_mode", 16'h0004, 16'h0000, 0, 0, 0, 0);
    btn_start = 1'b0; step(1);

    // Async reset mid-count (resumes with 2/10 s already accumulated)
    press_start(); step(15);
    chk("run_before_rst", 16'h0005, 16'h0000, 0, 0, 1, 0);
    step(1);
    rst = 1'b1; #1;
    chk("async_rst", 16'h0000, 16'h0000, 0, 0, 0, 0);
    step(2);
    rst = 1'b0; step(1);

    // Long run: minute carries and terminal count
    press_start();
    step(5999);  chk("pre_10min",   16'h0959, 16'h0000, 0, 0, 1, 0);
    step(1);     chk("carry_10min", 16'h1000, 16'h0000, 0, 0, 1, 0);
    step(53989); chk("at_9958",     16'h9958, 16'h0000, 0, 0, 1, 0);
    step(1);     chk("at_9959",     16'h9959, 16'h0000, 0, 0, 1, 0);
    step(9);     chk("hold_9959",   16'h9959, 16'h0000, 0, 0, 1, 0);
    step(1);
`ifdef STOPWATCH_WRAP_EN
    chk("terminal_wrap", 16'h0000, 16'h0000, 0, 0, 1, 0);
    press_start();
    chk("start_after_wrap", 16'h0000, 16'h0000, 0, 0, 0, 0);
`else
    chk("terminal_sat", 16'h9959, 16'h0000, 0, 0, 0, 1);
    press_start();
    chk("start_blocked", 16'h9959, 16'h0000, 0, 0, 0, 1);
`endif
    step(1); press_clear();
    chk("clear_all", 16'h0000, 16'h0000, 0, 0, 0, 0);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        step(1);
        budget--;
      end
      step(1);
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
